// File: rtl/nanci_phase_ctrl.sv
// Global sort/compute phase sequencer for the Nanci PE mesh.
// Steps through ITERS iterations of SORT then COMPUTE, with one-cycle DONE and abort.
module nanci_phase_ctrl #(
  parameter int SORT_CYCLES    = 4,
  parameter int COMPUTE_CYCLES = 2,
  parameter int ITERS          = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_halt,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_phase,
  output logic                 o_sort_en,
  output logic                 o_compute_en,
  output logic [1:0]           o_dir,
  output logic [CNT_WIDTH-1:0] o_step,
  output logic [CNT_WIDTH-1:0] o_iter
);

  localparam int CNT_MAX = (2 ** CNT_WIDTH) - 1;

  if (CNT_WIDTH < 2 || CNT_WIDTH > 30) begin : g_bad_width
    $error("nanci_phase_ctrl: CNT_WIDTH must be in 2..30");
  end
  if (SORT_CYCLES < 1 || SORT_CYCLES > CNT_MAX) begin : g_bad_sort
    $error("nanci_phase_ctrl: SORT_CYCLES out of range");
  end
  if (COMPUTE_CYCLES < 1 || COMPUTE_CYCLES > CNT_MAX) begin : g_bad_compute
    $error("nanci_phase_ctrl: COMPUTE_CYCLES out of range");
  end
  if (ITERS < 1 || ITERS > CNT_MAX) begin : g_bad_iters
    $error("nanci_phase_ctrl: ITERS out of range");
  end

  localparam logic [CNT_WIDTH-1:0] SORT_LAST    = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] COMPUTE_LAST = CNT_WIDTH'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ITER_LAST    = CNT_WIDTH'(ITERS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SORT    = 2'b01,
    COMPUTE = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t               state, nstate;
  logic [CNT_WIDTH-1:0] step, nstep;
  logic [CNT_WIDTH-1:0] iter, niter;

  always_comb begin
    nstate = state;
    nstep  = step;
    niter  = iter;
    if (i_halt) begin
      nstate = IDLE;
      nstep  = '0;
      niter  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nstep = '0;
          niter = '0;
          if (i_start) nstate = SORT;
        end
        SORT: begin
          if (step < SORT_LAST) begin
            nstep = step + CNT_ONE;
          end else begin
            nstate = COMPUTE;
            nstep  = '0;
          end
        end
        COMPUTE: begin
          if (step < COMPUTE_LAST) begin
            nstep = step + CNT_ONE;
          end else if (iter < ITER_LAST) begin
            nstate = SORT;
            nstep  = '0;
            niter  = iter + CNT_ONE;
          end else begin
            // iter is kept so the DONE cycle reports the final iteration index
            nstate = DONE;
            nstep  = '0;
          end
        end
        DONE: begin
          nstate = IDLE;
          nstep  = '0;
          niter  = '0;
        end
        default: begin
          nstate = IDLE;
          nstep  = '0;
          niter  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they change only on clk or rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      step         <= '0;
      iter         <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_phase      <= 2'b00;
      o_sort_en    <= 1'b0;
      o_compute_en <= 1'b0;
      o_dir        <= 2'b00;
      o_step       <= '0;
      o_iter       <= '0;
    end else begin
      state        <= nstate;
      step         <= nstep;
      iter         <= niter;
      o_busy       <= (nstate == SORT) || (nstate == COMPUTE);
      o_done       <= (nstate == DONE);
      o_phase      <= nstate;
      o_sort_en    <= (nstate == SORT);
      o_compute_en <= (nstate == COMPUTE);
      o_dir        <= (nstate == SORT) ? nstep[1:0] : 2'b00;
      o_step       <= ((nstate == SORT) || (nstate == COMPUTE)) ? nstep : '0;
      o_iter       <= (nstate == IDLE) ? '0 : niter;
    end
  end

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// Bench for nanci_phase_ctrl: two configurations against a timeline model, plus literal pins.
module tb_nanci_phase_ctrl;

  localparam int CW = 8;
  localparam int S0 = 4, C0 = 2, I0 = 2;
  localparam int S1 = 6, C1 = 2, I1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic i_halt = 1'b0;

  logic busy0, done0, sort0, comp0, busy1, done1, sort1, comp1;
  logic [1:0] phase0, dir0, phase1, dir1;
  logic [CW-1:0] step0, iter0, step1, iter1;

  nanci_phase_ctrl #(.SORT_CYCLES(S0), .COMPUTE_CYCLES(C0), .ITERS(I0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_halt(i_halt),
    .o_busy(busy0), .o_done(done0), .o_phase(phase0), .o_sort_en(sort0),
    .o_compute_en(comp0), .o_dir(dir0), .o_step(step0), .o_iter(iter0));

  nanci_phase_ctrl #(.SORT_CYCLES(S1), .COMPUTE_CYCLES(C1), .ITERS(I1), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_halt(i_halt),
    .o_busy(busy1), .o_done(done1), .o_phase(phase1), .o_sort_en(sort1),
    .o_compute_en(comp1), .o_dir(dir1), .o_step(step1), .o_iter(iter1));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: k = cycles since the accepted start (1 = first SORT cycle), 0 = idle.
  function automatic int next_k(int k, bit start, bit halt, int n);
    if (halt) return 0;
    if (k != 0) return (k == n + 1) ? 0 : k + 1;
    return start ? 1 : 0;
  endfunction

  // Packed {busy, done, phase, sort_en, compute_en, dir, step, iter}
  function automatic logic [23:0] model_out(int k, int s, int c, int it);
    int n, idx, per, r;
    logic [7:0] st, itr;
    n = it * (s + c);
    per = s + c;
    if (k == 0) return 24'h0;
    if (k == n + 1) begin
      itr = 8'(it - 1);
      return {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 8'h00, itr};
    end
    idx = k - 1;
    r = idx % per;
    itr = 8'(idx / per);
    if (r < s) begin
      st = 8'(r);
      return {1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'(r % 4), st, itr};
    end
    st = 8'(r - s);
    return {1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, st, itr};
  endfunction

  int k0 = 0, k1 = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k0 <= 0;
      k1 <= 0;
    end else begin
      k0 <= next_k(k0, i_start, i_halt, I0 * (S0 + C0));
      k1 <= next_k(k1, i_start, i_halt, I1 * (S1 + C1));
    end
  end

  logic [23:0] v0, v1;
  assign v0 = {busy0, done0, phase0, sort0, comp0, dir0, step0, iter0};
  assign v1 = {busy1, done1, phase1, sort1, comp1, dir1, step1, iter1};

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_cfg0", {8'h0, v0}, {8'h0, model_out(k0, S0, C0, I0)});
      chk("model_cfg1", {8'h0, v1}, {8'h0, model_out(k1, S1, C1, I1)});
    end
  end

  int ph0_tab[14]  = '{1, 1, 1, 1, 2, 2, 1, 1, 1, 1, 2, 2, 3, 0};
  int it0_tab[14]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int dir0_tab[14] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
  int dir1_tab[8]  = '{0, 1, 2, 3, 0, 1, 0, 0};
  int stp1_tab[8]  = '{0, 1, 2, 3, 4, 5, 0, 1};
  int done_cnt;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs0", {8'h0, v0}, 32'h0);
    chk("reset_outputs1", {8'h0, v1}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal run: start sampled at edge 0, observe cycles 1..14
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk("run_phase", {30'h0, phase0}, ph0_tab[c-1]);
      chk("run_iter", {24'h0, iter0}, it0_tab[c-1]);
      chk("run_dir", {30'h0, dir0}, dir0_tab[c-1]);
      chk("run_done", {31'h0, done0}, (c == 13) ? 1 : 0);
      if (c <= 8) begin
        chk("wrap_dir", {30'h0, dir1}, dir1_tab[c-1]);
        chk("wrap_step", {24'h0, step1}, stp1_tab[c-1]);
      end
      if (c == 9) chk("wrap_done", {31'h0, done1}, 1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Halt mid-COMPUTE
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("halt_pre_compute", {31'h0, comp0}, 1);
    i_halt = 1'b1;
    @(negedge clk);
    i_halt = 1'b0;
    chk("halt_phase", {30'h0, phase0}, 0);
    chk("halt_busy", {31'h0, busy0}, 0);
    chk("halt_iter", {24'h0, iter0}, 0);
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    chk("halt_no_done", done_cnt, 0);

    // Start held high through busy and DONE
    i_start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 13) chk("hold_done", {31'h0, done0}, 1);
      if (c == 14) chk("hold_idle", {30'h0, phase0}, 0);
      if (c == 15) begin
        chk("hold_restart_sort", {31'h0, sort0}, 1);
        chk("hold_restart_step", {24'h0, step0}, 0);
      end
    end
    i_start = 1'b0;
    repeat (20) @(negedge clk);

    // Start and halt together in IDLE
    i_start = 1'b1;
    i_halt  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_halt  = 1'b0;
    chk("start_halt0", {8'h0, v0}, 32'h0);
    chk("start_halt1", {8'h0, v1}, 32'h0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-SORT of iteration 1
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("arst_pre_sort", {31'h0, sort0}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_zero0", {8'h0, v0}, 32'h0);
    chk("arst_zero1", {8'h0, v1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (12) @(negedge clk);
    chk("arst_rerun_done", {31'h0, done0}, 1);
    repeat (2) @(negedge clk);

    // Random starts and halts
    repeat (3000) begin
      i_start = ($urandom_range(0, 3) == 0);
      i_halt  = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    i_start = 1'b0;
    i_halt  = 1'b0;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nanci_phase_ctrl.md
# nanci_phase_ctrl

Global phase sequencer for the Nanci PE mesh. It accepts a start request and steps every PE through the configured number of sort/compute iterations. For each iteration it emits:
- a sort phase of SORT_CYCLES cycles, with a per-cycle neighbour-direction select (l/r/u/d);
- a compute phase of COMPUTE_CYCLES cycles.

It sits above the PE array, and its outputs are broadcast unchanged to every PE. It finishes with a one-cycle done pulse and supports a synchronous abort.

## Interface

- SORT_CYCLES, 4, cycles per sort phase; legal range is 1 to 2^CNT_WIDTH-1
- COMPUTE_CYCLES, 2, cycles per compute phase; legal range is 1 to 2^CNT_WIDTH-1
- ITERS, 2, number of sort+compute iterations per run; legal range is 1 to 2^CNT_WIDTH-1
- CNT_WIDTH, 8, width of the step and iteration counters

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  run request; sampled only in IDLE
- i_halt  in  1  synchronous abort; takes effect in any state
- o_busy  out  1  high in SORT and COMPUTE
- o_done  out  1  one-cycle pulse when a run completes normally
- o_phase  out  2  current state: 00 IDLE, 01 SORT, 10 COMPUTE, 11 DONE
- o_sort_en  out  1  high in SORT
- o_compute_en  out  1  high in COMPUTE
- o_dir  out  2  neighbour select: 00 l, 01 r, 10 u, 11 d; forced to 00 outside SORT
- o_step  out  CNT_WIDTH  cycle index within the current phase; 0 outside SORT/COMPUTE
- o_iter  out  CNT_WIDTH  current iteration index; 0 in IDLE

## Operation

- Outputs are Moore-style and decoded from registered state and counters only. There are no combinational paths from inputs to outputs.
- Reset value of every output is 0; state after reset is IDLE.
- IDLE:
  - i_start=1 and i_halt=0 → SORT with step=0, iter=0.
  - Otherwise stay in IDLE.
- SORT:
  - o_dir = step[1:0], giving the sequence l, r, u, d, l, …
  - While step < SORT_CYCLES-1, increment step.
  - Otherwise → COMPUTE with step=0.
- COMPUTE:
  - While step < COMPUTE_CYCLES-1, increment step.
  - Otherwise, if iter < ITERS-1 → SORT with step=0 and iter+1.
  - Otherwise → DONE.
- DONE:
  - o_done=1 and o_busy=0 for exactly one cycle, then → IDLE.
  - o_iter holds ITERS-1 during this cycle and returns to 0 in IDLE.
- i_halt=1 in any state: next state is IDLE and step and iter clear. This path never asserts o_done.
- i_halt has priority over i_start and over every other transition.
- i_start outside IDLE is ignored, including in the DONE cycle. It is not queued.
- Counters compare with ==/< against the parameters in CNT_WIDTH bits and never wrap within legal parameter ranges.
- An elaboration-time check rejects any parameter outside its legal range.

## Timing

- Start latency: with i_start sampled at edge t, o_sort_en is high in cycle t+1 with o_dir=00 and o_step=0.
- Run length: o_done pulses in cycle t + ITERS×(SORT_CYCLES+COMPUTE_CYCLES) + 1.
- Phase boundaries have no bubble cycles:
  - the last SORT cycle is immediately followed by the first COMPUTE cycle;
  - the last COMPUTE cycle is immediately followed by the next SORT cycle or by DONE.
- Back-to-back runs: the earliest next start is sampled in the IDLE cycle after DONE. That gives one dead cycle (DONE) plus the IDLE sampling cycle.
- Halt latency: with i_halt sampled at edge t, outputs show IDLE values in cycle t+1.
- Reset: on rst assertion (asynchronous, mid-run included), all outputs go to 0 immediately, without waiting for a clock edge. Operation resumes from IDLE on the first edge after deassertion.

## Test plan

- **Normal run, defaults:** reset, then a one-cycle i_start sampled at edge 0.
  - SORT in cycles 1–4 with o_dir 00,01,10,11.
  - COMPUTE in cycles 5–6, then SORT 7–10 (o_iter=1), then COMPUTE 11–12.
  - o_done=1 only in cycle 13; IDLE with all outputs 0 in cycle 14.
- **Direction wrap:** SORT_CYCLES=6, ITERS=1. o_dir runs 00,01,10,11,00,01, and o_step runs 0..5, then 0..1 in COMPUTE.
- **Halt mid-COMPUTE:** i_halt in cycle 5 of a default run. Cycle 6 is IDLE, o_busy=0, o_iter=0, and o_done never pulses.
- **Start ignored while busy and in DONE:** i_start held high for cycles 0–20.
  - The first run completes with o_done in cycle 13.
  - The IDLE sample at edge 14 starts a second run; SORT begins in cycle 15.
- **Start and halt together in IDLE:** both high at one edge. The block stays in IDLE and all outputs remain 0.
- **Asynchronous reset mid-SORT:** assert rst between edges in cycle 8. All outputs are 0 before the next edge. After deassertion, a fresh i_start gives the full 13-cycle run.
